// File: rtl/mem_responder.sv
// mem_responder
// Memory-side responder for the multicycle MIPS control FSM and datapath.
// Accepts one read/write request at a time on a valid/ready handshake and
// answers it from an internal word array after WAIT_CYCLES wait states.
// A one-cycle o_resp_valid strobe marks the response. Instruction-fetch reads
// also latch the opcode field (bits [31:26]) of the fetched word.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_reset       asynchronous, active-high reset
//   i_req_valid   request present
//   i_req_write   1 = write, 0 = read (sampled with i_req_valid)
//   i_req_fetch   1 = instruction-fetch read (sampled with i_req_valid)
//   i_addr        word address
//   i_wdata       write data
//   o_req_ready   responder can accept a request (state == IDLE)
//   o_resp_valid  one-cycle response strobe
//   o_rdata       response data, valid while o_resp_valid = 1
//   o_opcode      bits [31:26] of the last fetched word
//   o_busy        request in progress (state != IDLE)
//   o_stateout    current state encoding, for debug
//
// State | meaning
// IDLE  | ready for a request
// WAIT  | counting wait states; inputs ignored
// RESP  | response strobe cycle; returns to IDLE unconditionally

module mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    input  logic              i_req_write,
    input  logic              i_req_fetch,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic              o_req_ready,
    output logic              o_resp_valid,
    output logic [DATA_W-1:0] o_rdata,
    output logic [5:0]        o_opcode,
    output logic              o_busy,
    output logic [1:0]        o_stateout
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT    = 2'd1,
        S_RESP    = 2'd2,
        S_ILLEGAL = 2'd3
    } state_t;

    localparam int              IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W + 1)'(DEPTH);
    localparam logic [3:0]      WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;

    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic                r_write;
    logic                r_fetch;
    logic [DATA_W-1:0]   r_rdata;
    logic [5:0]          r_opcode;
    logic [DATA_W-1:0]   r_mem [DEPTH];

    logic                w_accept;
    logic                w_commit;
    logic [ADDR_W-1:0]   w_c_addr;
    logic [DATA_W-1:0]   w_c_wdata;
    logic                w_c_write;
    logic                w_c_fetch;
    logic                w_in_range;
    logic [IDX_W-1:0]    w_idx;
    logic [DATA_W-1:0]   w_mem_rd;

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_busy       = (r_state != S_IDLE);
    assign o_resp_valid = (r_state == S_RESP);
    assign o_stateout   = r_state;
    assign o_rdata      = r_rdata;
    assign o_opcode     = r_opcode;

    assign w_accept = i_req_valid && o_req_ready;

    // --- FSM state register ---
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // --- FSM next state ---
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt = S_RESP;
                    end else begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = WAIT_LOAD;
                    end
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // The commit happens on the edge that enters RESP. With zero wait states
    // that is the accept edge itself, so the request fields come straight
    // from the inputs instead of the latched copies.
    assign w_commit   = (w_state_nxt == S_RESP) && (r_state != S_RESP);
    assign w_c_addr   = (r_state == S_IDLE) ? i_addr      : r_addr;
    assign w_c_wdata  = (r_state == S_IDLE) ? i_wdata     : r_wdata;
    assign w_c_write  = (r_state == S_IDLE) ? i_req_write : r_write;
    assign w_c_fetch  = (r_state == S_IDLE) ? i_req_fetch : r_fetch;

    assign w_in_range = ({1'b0, w_c_addr} < DEPTH_L);
    assign w_idx      = w_c_addr[IDX_W-1:0];
    assign w_mem_rd   = w_in_range ? r_mem[w_idx] : '0;

    // --- request latch and response registers ---
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr   <= '0;
            r_wdata  <= '0;
            r_write  <= 1'b0;
            r_fetch  <= 1'b0;
            r_rdata  <= '0;
            r_opcode <= 6'd0;
        end else begin
            if (w_accept) begin
                r_addr  <= i_addr;
                r_wdata <= i_wdata;
                r_write <= i_req_write;
                r_fetch <= i_req_fetch;
            end
            if (w_commit) begin
                if (w_c_write) begin
                    r_rdata <= w_c_wdata;
                end else begin
                    r_rdata <= w_mem_rd;
                    if (w_c_fetch) begin
                        r_opcode <= w_mem_rd[31:26];
                    end
                end
            end
        end
    end

    // --- word array (not reset); a write held in reset never commits ---
    always_ff @(posedge i_clk) begin
        if (!i_reset && w_commit && w_c_write && w_in_range) begin
            r_mem[w_idx] <= w_c_wdata;
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
Memory-side responder for the multicycle MIPS control FSM and datapath. It accepts one read or write request at a time over a valid/ready handshake and services it from an internal word array after a programmable number of wait states. It returns read data with a one-cycle response strobe. On instruction-fetch reads it also registers the fetched opcode field that the control FSM decodes.

Parameters:
ADDR_W, 8, word-address width
DATA_W, 32, data word width; must be >= 32 because Opcode is taken from bits [31:26]
DEPTH, 256, number of implemented words; must be <= 2^ADDR_W
WAIT_CYCLES, 2, wait states between request accept and response; legal range 0..15

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-high reset
ReqValid  in  1  request present
ReqWrite  in  1  1 = write, 0 = read; sampled with ReqValid
ReqFetch  in  1  1 = instruction-fetch read; sampled with ReqValid
Addr  in  ADDR_W  word address
WData  in  DATA_W  write data
ReqReady  out  1  responder can accept a request
RespValid  out  1  one-cycle response strobe
RData  out  DATA_W  response data, valid only while RespValid = 1
Opcode  out  6  bits [31:26] of the last fetched word
Busy  out  1  request in progress (state is not IDLE)
Stateout  out  2  current state encoding, for debug

Behaviour:
- States: IDLE = 0, WAIT = 1, RESP = 2. Encoding 3 is illegal and goes to IDLE on the next edge.
- Reset (asynchronous) forces: state IDLE, wait counter 0, RespValid 0, RData 0, Opcode 0, latched request fields 0. Memory array contents are not reset.
- Reset asserted mid-operation aborts the request. A write that has not yet reached its commit edge is not performed.
- ReqReady = (state == IDLE), combinational from state.
- Busy = (state != IDLE).
- Accept: at a rising edge with ReqValid = 1 and ReqReady = 1, latch Addr, WData, ReqWrite and ReqFetch.
  - If WAIT_CYCLES == 0, next state is RESP.
  - Otherwise, next state is WAIT and the counter loads WAIT_CYCLES - 1.
- WAIT: if the counter is 0, go to RESP; otherwise decrement the counter. Inputs are ignored in WAIT.
- Commit edge is the edge that enters RESP:
  - Write: mem[addr] <= wdata; RData <= wdata (echo).
  - Read: RData <= mem[addr].
  - Fetch read additionally: Opcode <= mem[addr][31:26].
  - Opcode holds its value across writes and non-fetch reads.
- RESP: RespValid = 1 for exactly one cycle, then unconditionally back to IDLE. ReqValid in RESP is ignored because ReqReady = 0.
- Latency: RespValid is high in cycle accept + WAIT_CYCLES + 1. Maximum throughput is one request per WAIT_CYCLES + 2 cycles.
- RespValid is 0 in IDLE and WAIT. RData holds its last value outside RESP.
- Addresses >= DEPTH: reads return 0, writes are dropped, and a fetch sets Opcode = 0. The response is still given with normal timing.
- ReqWrite = 1 together with ReqFetch = 1: treated as a write; Opcode is not updated.
- ReqValid deasserting after accept has no effect on the request in progress.

Test Plan:
- Reset during WAIT of a write (Addr = 0x05, WData = 0xDEADBEEF) -> state is 0 and RespValid = 0 immediately, ReqReady = 1 after release; a later read of 0x05 returns the previous contents.
- WAIT_CYCLES = 2: write 0x12345678 to 0x10, then fetch 0x10 -> each RespValid rises 3 cycles after its accept edge; fetch RData = 0x12345678 and Opcode = 0x04.
- Fetch word 0x8C000000 at 0x20 (Opcode 0x23), then a plain read of a word with opcode 0x00 -> Opcode stays 0x23 after the plain read.
- ReqValid held high continuously, WAIT_CYCLES = 0 -> one accept every 2 cycles, RespValid pattern 0,1,0,1; ReqReady low in every RESP cycle.
- DEPTH = 16: write 0xFFFFFFFF to 0x20, then read 0x20 -> RespValid given with normal timing, RData = 0; addresses 0x00..0x0F unchanged.
- ReqWrite = 1 and ReqFetch = 1 with WData = 0xFC000000 -> memory is written, RData echoes 0xFC000000, Opcode is unchanged.
